// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - iterative radix-2 restoring floating-point divider
// Y = A / B with valid/ready handshake, RNE rounding, flush-to-zero, error/overflow flags.
module fdiv_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     Y,
    output logic                     error,
    output logic                     overflow
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int QW = MAN_W + 3;
    localparam int RW = MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 4);
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b, r_y;
    logic            r_err, r_ovf;
    logic [RW-1:0]   r_rem;
    logic [QW-1:0]   r_q;
    logic [CW-1:0]   r_cnt;

    // {nan, inf, zero}; exp==0 counts as zero regardless of fraction
    function automatic logic [2:0] classify(input logic [W-1:0] x);
        logic e_ones, e_zero, f_zero;
        e_ones = &x[W-2:MAN_W];
        e_zero = ~|x[W-2:MAN_W];
        f_zero = ~|x[MAN_W-1:0];
        return {e_ones & ~f_zero, e_ones & f_zero, e_zero};
    endfunction

    logic [2:0] w_in_ca, w_in_cb, w_ca, w_cb;
    logic       w_in_special;
    assign w_in_ca      = classify(A);
    assign w_in_cb      = classify(B);
    assign w_in_special = |{w_in_ca, w_in_cb};
    assign w_ca         = classify(r_a);
    assign w_cb         = classify(r_b);

    logic [RW-1:0] w_mb, w_diff, w_sel, w_rem_next;
    logic          w_qbit;
    assign w_mb       = {1'b0, 1'b1, r_b[MAN_W-1:0]};
    assign w_qbit     = (r_rem >= w_mb);
    assign w_diff     = r_rem - w_mb;
    assign w_sel      = w_qbit ? w_diff : r_rem;
    assign w_rem_next = {w_sel[RW-2:0], 1'b0};

    // quotient is in (0.5, 2): keep leading one, MAN_W fraction bits and a guard bit
    logic                 w_top, w_sticky, w_rup, w_carry, w_s;
    logic [RW-1:0]        w_mant;
    logic [MAN_W+1:0]     w_sum;
    logic [MAN_W-1:0]     w_frac;
    logic signed [EW-1:0] w_e;
    assign w_top    = r_q[QW-1];
    assign w_mant   = w_top ? r_q[QW-1:1] : r_q[QW-2:0];
    assign w_sticky = (|r_rem) | (w_top & r_q[0]);
    assign w_rup    = w_mant[0] & (w_sticky | w_mant[1]);
    assign w_sum    = {1'b0, w_mant[RW-1:1]} + (MAN_W+2)'(w_rup);
    assign w_carry  = w_sum[MAN_W+1];
    assign w_frac   = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
    assign w_e      = $signed({2'b00, r_a[W-2:MAN_W]}) - $signed({2'b00, r_b[W-2:MAN_W]})
                    + BIAS - $signed(EW'(!w_top)) + $signed(EW'(w_carry));
    assign w_s      = r_a[W-1] ^ r_b[W-1];

    logic [W-1:0] w_y, w_inf, w_nan, w_zero;
    logic         w_err, w_ovf;
    assign w_inf  = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_nan  = {w_s, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    assign w_zero = {w_s, {(W-1){1'b0}}};

    always_comb begin
        w_y   = {w_s, w_e[EXP_W-1:0], w_frac};
        w_err = 1'b0;
        w_ovf = 1'b0;
        if (w_ca[2] || w_cb[2] || (w_ca[0] && w_cb[0]) || (w_ca[1] && w_cb[1])) begin
            w_y   = w_nan;
            w_err = 1'b1;
        end else if (w_ca[1]) begin
            w_y = w_inf;
        end else if (w_cb[0]) begin
            w_y   = w_inf;
            w_err = 1'b1;
        end else if (w_ca[0] || w_cb[1]) begin
            w_y = w_zero;
        end else if (w_e >= EMAX) begin
            w_y   = w_inf;
            w_ovf = 1'b1;
        end else if (w_e <= 0) begin
            w_y = w_zero;
        end
    end

    // specials bypass the iteration and resolve through NORM one edge after accept
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = w_in_special ? S_NORM : S_DIV;
            S_DIV:  if (r_cnt == CW'(1)) w_next = S_NORM;
            S_NORM: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a   <= A;
                    r_b   <= B;
                    r_rem <= {1'b0, 1'b1, A[MAN_W-1:0]};
                    r_q   <= '0;
                    r_cnt <= CW'(QW);
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[QW-2:0], w_qbit};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_NORM: begin
                    r_y   <= w_y;
                    r_err <= w_err;
                    r_ovf <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign Y         = r_y;
    assign error     = r_err;
    assign overflow  = r_ovf;
endmodule
